// File: rtl/sigpath_pkg.sv
// Shared definitions for the audio signal path: default widths, the silence
// level and the fade controller state type.
package sigpath_pkg;

    localparam int DATA_WIDTH_DEF    = 8;
    localparam int ADDRESS_WIDTH_DEF = 9;
    localparam int GAIN_WIDTH_DEF    = 4;

    localparam logic [DATA_WIDTH_DEF-1:0] MIDSCALE = 8'h80;

    typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

    typedef enum logic [1:0] {
        MUTE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } fade_state_t;

endpackage

// File: rtl/echo_fade_ctrl.sv
// Fade controller: mutes the wet path until the delay line is refilled after
// a reset or offset change, then ramps the wet gain up to its target.
module echo_fade_ctrl
    import sigpath_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int GAIN_WIDTH    = GAIN_WIDTH_DEF,
    parameter int FADE_SHIFT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic [GAIN_WIDTH-1:0]    gain,
    output logic [GAIN_WIDTH-1:0]    eff_gain,
    output logic                     fade_busy
);

    localparam int CW = ADDRESS_WIDTH + 1;
    localparam int RW = (FADE_SHIFT > 0) ? FADE_SHIFT : 1;
    localparam logic [RW-1:0] RAMP_MAX = RW'((1 << FADE_SHIFT) - 1);

    fade_state_t              state_r, state_n;
    logic [CW-1:0]            mute_cnt_r, mute_cnt_n, mute_inc_s;
    logic [RW-1:0]            ramp_cnt_r, ramp_cnt_n;
    logic [GAIN_WIDTH-1:0]    eff_gain_r, eff_gain_n;
    logic [ADDRESS_WIDTH-1:0] offset_q_r;
    logic                     fade_busy_r;
    logic                     offset_chg_s;

    assign offset_chg_s = (offset != offset_q_r);
    // The count including the current strobe lets the last muted sample trigger RAMP
    assign mute_inc_s   = mute_cnt_r + CW'(en);

    // Next-state and counter logic; an offset change overrides everything else
    always_comb begin
        state_n    = state_r;
        mute_cnt_n = mute_cnt_r;
        ramp_cnt_n = ramp_cnt_r;
        eff_gain_n = eff_gain_r;
        if (offset_chg_s) begin
            state_n    = MUTE;
            mute_cnt_n = '0;
            ramp_cnt_n = '0;
            eff_gain_n = '0;
        end else begin
            case (state_r)
                MUTE: begin
                    eff_gain_n = '0;
                    ramp_cnt_n = '0;
                    if (mute_inc_s >= CW'(offset)) begin
                        state_n    = RAMP;
                        mute_cnt_n = '0;
                    end else begin
                        mute_cnt_n = mute_inc_s;
                    end
                end
                RAMP: begin
                    if (eff_gain_r >= gain) begin
                        state_n    = RUN;
                        eff_gain_n = gain;
                    end else if (en) begin
                        if (ramp_cnt_r == RAMP_MAX) begin
                            eff_gain_n = eff_gain_r + GAIN_WIDTH'(1);
                            ramp_cnt_n = '0;
                        end else begin
                            ramp_cnt_n = ramp_cnt_r + RW'(1);
                        end
                    end else begin
                        eff_gain_n = eff_gain_r;
                    end
                end
                RUN: begin
                    eff_gain_n = gain;
                end
                default: begin
                    state_n    = MUTE;
                    mute_cnt_n = '0;
                    ramp_cnt_n = '0;
                    eff_gain_n = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= MUTE;
            mute_cnt_r  <= '0;
            ramp_cnt_r  <= '0;
            eff_gain_r  <= '0;
            offset_q_r  <= '0;
            fade_busy_r <= 1'b1;
        end else begin
            state_r     <= state_n;
            mute_cnt_r  <= mute_cnt_n;
            ramp_cnt_r  <= ramp_cnt_n;
            eff_gain_r  <= eff_gain_n;
            offset_q_r  <= offset;
            fade_busy_r <= (state_n != RUN);
        end
    end

    assign eff_gain  = eff_gain_r;
    assign fade_busy = fade_busy_r;

endmodule

// File: rtl/echo_mixer.sv
// Echo mixer: aligns the dry sample with the delayed RAM read, scales the wet
// path by the faded gain and adds both with saturation.
module echo_mixer
    import sigpath_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int GAIN_WIDTH    = GAIN_WIDTH_DEF,
    parameter int RD_LAT        = 1,
    parameter int FADE_SHIFT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_WIDTH-1:0]    dry_in,
    input  logic [DATA_WIDTH-1:0]    wet_in,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic [GAIN_WIDTH-1:0]    gain,
    output logic [DATA_WIDTH-1:0]    mix_out,
    output logic                     mix_valid,
    output logic                     fade_busy
);

    localparam int PW     = DATA_WIDTH + GAIN_WIDTH;
    localparam int SW     = DATA_WIDTH + 2;
    localparam int SAT_HI = (1 << (DATA_WIDTH - 1)) - 1;
    localparam int SAT_LO = -(1 << (DATA_WIDTH - 1));
    localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [GAIN_WIDTH-1:0]  eff_gain_s;
    logic [RD_LAT-1:0]      vld_pipe_r;
    logic [DATA_WIDTH-1:0]  dry_pipe_r  [RD_LAT];
    logic [GAIN_WIDTH-1:0]  gain_pipe_r [RD_LAT];
    logic                   vld_m_r;
    logic [DATA_WIDTH-1:0]  dry_m_r;
    logic signed [PW-1:0]   prod_r;
    logic signed [DATA_WIDTH-1:0] wet_s, dry_s, sat_s;
    logic signed [PW-1:0]   wet_x_s, gain_x_s, prod_s;
    logic signed [SW-1:0]   sum_s;
    logic [DATA_WIDTH-1:0]  mix_s;
    logic [DATA_WIDTH-1:0]  mix_out_r;
    logic                   mix_valid_r;

    echo_fade_ctrl #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .GAIN_WIDTH   (GAIN_WIDTH),
        .FADE_SHIFT   (FADE_SHIFT)
    ) u_fade (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .offset   (offset),
        .gain     (gain),
        .eff_gain (eff_gain_s),
        .fade_busy(fade_busy)
    );

    // Sample-valid flags for the RAM-latency alignment stages
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_r <= '0;
        end else begin
            vld_pipe_r[0] <= en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
            end
        end
    end

    // Dry sample and gain travel alongside the valid flag; no reset needed
    always_ff @(posedge clk) begin
        dry_pipe_r[0]  <= dry_in;
        gain_pipe_r[0] <= eff_gain_s;
        for (int i = 1; i < RD_LAT; i++) begin
            dry_pipe_r[i]  <= dry_pipe_r[i-1];
            gain_pipe_r[i] <= gain_pipe_r[i-1];
        end
    end

    // Offset-binary to two's complement is an MSB flip
    assign wet_s    = {~wet_in[DATA_WIDTH-1], wet_in[DATA_WIDTH-2:0]};
    assign wet_x_s  = PW'(wet_s);
    assign gain_x_s = $signed(PW'(gain_pipe_r[RD_LAT-1]));
    assign prod_s   = wet_x_s * gain_x_s;

    // Multiply stage
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_m_r <= 1'b0;
            dry_m_r <= MID;
            prod_r  <= '0;
        end else begin
            vld_m_r <= vld_pipe_r[RD_LAT-1];
            dry_m_r <= dry_pipe_r[RD_LAT-1];
            prod_r  <= prod_s;
        end
    end

    assign dry_s = {~dry_m_r[DATA_WIDTH-1], dry_m_r[DATA_WIDTH-2:0]};
    assign sum_s = SW'(dry_s) + SW'(prod_r >>> GAIN_WIDTH);

    // Clamp the wide sum to the sample range and return to offset-binary
    always_comb begin
        sat_s = DATA_WIDTH'(sum_s);
        if (sum_s > SW'(SAT_HI)) begin
            sat_s = DATA_WIDTH'(SAT_HI);
        end else if (sum_s < SW'(SAT_LO)) begin
            sat_s = DATA_WIDTH'(SAT_LO);
        end else begin
            sat_s = DATA_WIDTH'(sum_s);
        end
        mix_s = {~sat_s[DATA_WIDTH-1], sat_s[DATA_WIDTH-2:0]};
    end

    // Output stage; mix_out holds between valid pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_out_r   <= MID;
            mix_valid_r <= 1'b0;
        end else begin
            mix_valid_r <= vld_m_r;
            if (vld_m_r) begin
                mix_out_r <= mix_s;
            end else begin
                mix_out_r <= mix_out_r;
            end
        end
    end

    assign mix_out   = mix_out_r;
    assign mix_valid = mix_valid_r;

endmodule

// File: tb/tb_echo_mixer.sv
// Directed and randomized bench for echo_mixer with a sample-level reference
// model of the fade schedule and the saturating mix.
module tb_echo_mixer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] dry_in = 8'h80;
    logic [7:0] wet_in = 8'h80;
    logic [8:0] offset = 9'd0;
    logic [3:0] gain = 4'd8;
    logic [7:0] mix_out;
    logic       mix_valid;
    logic       fade_busy;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] wet_pend = 8'h80;
    logic [7:0] last_out = 8'h80;
    logic       sched_v [4];
    logic [7:0] sched_d [4];
    int         k_since = 0;
    bit         model_run = 1'b0;

    echo_mixer #(.FADE_SHIFT(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dry_in   (dry_in),
        .wet_in   (wet_in),
        .offset   (offset),
        .gain     (gain),
        .mix_out  (mix_out),
        .mix_valid(mix_valid),
        .fade_busy(fade_busy)
    );

    always #5 clk = ~clk;

    // Saturating mix of two offset-binary samples with a gain of g/16
    function automatic logic [7:0] mix_ref(input logic [7:0] d, input logic [7:0] w, input int g);
        int ds, ws, p, q, s;
        ds = int'(d) - 128;
        ws = int'(w) - 128;
        p  = ws * g;
        q  = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        s  = ds + q;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s + 128);
    endfunction

    // Gain for the k-th sample after an offset change: muted for `offset`
    // samples, then one step per sample until the target is reached.
    function automatic int gain_ref();
        int r;
        if (k_since < int'(offset)) begin
            r = 0;
        end else if (model_run) begin
            r = int'(gain);
        end else if (k_since - int'(offset) >= int'(gain)) begin
            model_run = 1'b1;
            r = int'(gain);
        end else begin
            r = k_since - int'(offset);
        end
        k_since++;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick(input logic e, input logic [7:0] d, input logic [7:0] w);
        int slot;
        en      = e;
        dry_in  = d;
        wet_in  = wet_pend;
        wet_pend = w;
        if (rst) begin
            for (int i = 0; i < 4; i++) sched_v[i] = 1'b0;
            last_out  = 8'h80;
            k_since   = 0;
            model_run = 1'b0;
        end else if (e) begin
            slot = (cyc + 3) % 4;
            sched_v[slot] = 1'b1;
            sched_d[slot] = mix_ref(d, w, gain_ref());
        end
        @(posedge clk);
        #1;
        cyc++;
        slot = cyc % 4;
        chk("mix_valid", {7'd0, mix_valid}, {7'd0, sched_v[slot]});
        if (sched_v[slot]) last_out = sched_d[slot];
        chk("mix_out", mix_out, last_out);
        sched_v[slot] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h80, 8'h80);
    endtask

    task automatic set_offset(input logic [8:0] o);
        offset    = o;
        k_since   = 0;
        model_run = 1'b0;
        tick(1'b0, 8'h80, 8'h80);
        chk("busy_after_offset", {7'd0, fade_busy}, 8'd1);
        idle(1);
    endtask

    initial begin
        int off_i;
        for (int i = 0; i < 4; i++) begin
            sched_v[i] = 1'b0;
            sched_d[i] = 8'h80;
        end

        // Reset for two cycles, then idle with no strobes
        rst = 1'b1;
        tick(1'b0, 8'h80, 8'h80);
        chk("reset_busy", {7'd0, fade_busy}, 8'd1);
        tick(1'b0, 8'h80, 8'h80);
        rst = 1'b0;
        idle(4);
        chk("idle_busy", {7'd0, fade_busy}, 8'd1);

        // offset 0, gain 8: ramp to RUN with silent samples
        for (int i = 0; i < 10; i++) tick(1'b1, 8'h80, 8'h80);
        idle(3);
        chk("run_reached", {7'd0, fade_busy}, 8'd0);

        // Latency and basic mix: expect 0xE0 exactly three cycles later
        tick(1'b1, 8'hC0, 8'hC0);
        idle(4);
        chk("mix_e0", mix_out, 8'hE0);

        // Saturation high, low, and gain 0 passes dry only
        gain = 4'd15;
        idle(2);
        tick(1'b1, 8'hFF, 8'hFF);
        tick(1'b1, 8'h00, 8'h00);
        idle(3);
        chk("sat_low", mix_out, 8'h00);
        gain = 4'd0;
        idle(2);
        tick(1'b1, 8'h37, 8'hF0);
        idle(3);
        chk("gain0_dry", mix_out, 8'h37);

        // Mute then ramp: offset 4, gain 3, strobe every cycle
        gain = 4'd3;
        set_offset(9'd4);
        for (int i = 0; i < 12; i++) tick(1'b1, 8'h80, 8'hC0);
        idle(3);
        chk("ramp_done_busy", {7'd0, fade_busy}, 8'd0);
        chk("ramp_final", mix_out, 8'h8C);

        // Offset change 4 -> 6 while in RUN
        set_offset(9'd6);
        for (int i = 0; i < 14; i++) tick(1'b1, 8'($urandom), 8'($urandom));
        idle(3);

        // Gain lowered during RAMP below the current effective gain
        gain = 4'd15;
        set_offset(9'd2);
        for (int i = 0; i < 7; i++) tick(1'b1, 8'h80, 8'hC0);
        gain = 4'd2;
        idle(2);
        chk("lower_gain_busy", {7'd0, fade_busy}, 8'd0);
        for (int i = 0; i < 3; i++) tick(1'b1, 8'h80, 8'hC0);
        idle(3);
        chk("lower_gain_out", mix_out, 8'h88);

        // Randomized rounds: new offset and gain, sparse strobes, random data
        off_i = 2;
        for (int r = 0; r < 8; r++) begin
            off_i = ((off_i - 1 + int'($urandom_range(1, 6))) % 7) + 1;
            gain  = 4'($urandom_range(0, 15));
            set_offset(9'(off_i));
            for (int i = 0; i < 40; i++)
                tick(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        // Reset with samples in flight: none of them may appear
        tick(1'b1, 8'hFF, 8'hFF);
        tick(1'b1, 8'hFF, 8'hFF);
        rst = 1'b1;
        tick(1'b1, 8'hFF, 8'hFF);
        chk("midrst_busy", {7'd0, fade_busy}, 8'd1);
        rst = 1'b0;
        idle(5);
        chk("midrst_out", mix_out, 8'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
